// File: rtl/kronos_imem_responder_pkg.sv
// Shared types for the Kronos instruction-memory responder: FSM state
// encoding and the NOP word returned for out-of-range fetches.
package kronos_types;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        ACK     = 2'd2
    } imem_state_e;

endpackage

// File: rtl/kronos_imem_responder.sv
// Instruction-fetch responder in front of an external single-port SRAM:
// accepts one fetch per cycle when pipelined, adds WAIT stall cycles per access.
//
// state   | meaning
// IDLE    | no access outstanding
// WAITING | access accepted, counting down wait states
// ACK     | ack cycle; a new fetch may be accepted here
module kronos_imem_responder
    import kronos_types::*;
#(
    parameter int  WORDS = 256,
    parameter int  WAIT  = 0,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic [31:0]   instr_addr,
    input  logic          instr_req,
    output logic [31:0]   instr_data,
    output logic          instr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    input  logic [31:0]   mem_rdata,
    input  logic          arb_busy
);

    localparam logic [29:0] WORDS_W = 30'(WORDS);
    localparam logic [2:0]  WAIT_C  = 3'(WAIT);

    imem_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        oob_q, oob_d;

    logic in_range;
    logic accept;
    logic unused_addr_bits;

    assign unused_addr_bits = ^instr_addr[1:0];

    assign in_range = (instr_addr[31:2] < WORDS_W);
    // Only WAITING blocks acceptance; ACK retires its access this cycle.
    assign accept   = rstz & instr_req & ~arb_busy & (state_q != WAITING);
    assign mem_en   = accept & in_range;
    assign mem_addr = instr_addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE, ACK: begin
                if (accept) begin
                    oob_d = ~in_range;
                    if (WAIT == 0) begin
                        state_d = ACK;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = WAITING;
                        cnt_d   = WAIT_C;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAITING: begin
                // First WAITING cycle is the one where the SRAM presents data.
                if (cnt_q == WAIT_C) begin
                    data_d = mem_rdata;
                end
                cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            oob_q   <= oob_d;
        end
    end

    always_comb begin
        instr_ack  = (state_q == ACK);
        instr_data = 32'd0;
        if (instr_ack) begin
            if (oob_q) begin
                instr_data = INSTR_NOP;
            end else if (WAIT == 0) begin
                instr_data = mem_rdata;
            end else begin
                instr_data = data_q;
            end
        end
    end

endmodule
